// File: rtl/cla_iter_subtractor_pkg.sv
// Shared parameters for the iterative CLA subtractor: group width, FSM
// state encodings and a counter-width helper.
package cla_iter_subtractor_pkg;

    localparam int CLA_GRP_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Group counter needs at least one bit even when there is a single group.
    function automatic int cnt_width(input int ngrp);
        return (ngrp > 1) ? $clog2(ngrp) : 1;
    endfunction

endpackage

// File: rtl/cla_grp_slice.sv
// Combinational W-bit carry-lookahead adder group: s = x + y + ci, co = carry-out.
module cla_grp_slice #(
    parameter int W = 4
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co
);

    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W:0]   c;

    assign g = x & y;
    assign p = x ^ y;

    // Each carry is a flat sum of products of generate/propagate terms,
    // so no carry depends on the previous bit's carry.
    always_comb begin
        logic t;
        t    = 1'b0;
        c    = '0;
        c[0] = ci;
        for (int i = 0; i < W; i++) begin
            c[i+1] = ci;
            for (int j = 0; j <= i; j++) begin
                c[i+1] = c[i+1] & p[j];
            end
            for (int k = 0; k <= i; k++) begin
                t = g[k];
                for (int j = k + 1; j <= i; j++) begin
                    t = t & p[j];
                end
                c[i+1] = c[i+1] | t;
            end
        end
    end

    assign s  = p ^ c[W-1:0];
    assign co = c[W];

endmodule

// File: rtl/cla_iter_subtractor.sv
// Multi-cycle unsigned subtractor: diff = a - b - bin, one CLA group per
// clock (LSB group first), valid/ready handshake on input and output.
module cla_iter_subtractor
    import cla_iter_subtractor_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  bin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] diff,
    output logic                  borrow,
    output logic                  zero
);

    localparam int W     = CLA_GRP_WIDTH;
    localparam int NGRP  = DATA_WIDTH / W;
    localparam int CNT_W = cnt_width(NGRP);
    localparam logic [CNT_W-1:0] LAST_GRP = CNT_W'(NGRP - 1);

    state_t                state;
    state_t                state_nxt;
    logic [CNT_W-1:0]      grp;
    logic                  carry;
    logic [DATA_WIDTH-1:0] a_reg;
    logic [DATA_WIDTH-1:0] nb_reg;
    logic [DATA_WIDTH-1:0] diff_reg;
    logic [DATA_WIDTH-1:0] diff_nxt;
    logic                  borrow_reg;
    logic                  zero_reg;
    logic [W-1:0]          slice_x;
    logic [W-1:0]          slice_y;
    logic [W-1:0]          slice_s;
    logic                  slice_co;
    logic                  last_grp;

    assign last_grp = (grp == LAST_GRP);
    assign slice_x  = a_reg[int'(grp)*W +: W];
    assign slice_y  = nb_reg[int'(grp)*W +: W];

    cla_grp_slice #(.W(W)) u_slice (
        .x  (slice_x),
        .y  (slice_y),
        .ci (carry),
        .s  (slice_s),
        .co (slice_co)
    );

    always_comb begin
        diff_nxt                      = diff_reg;
        diff_nxt[int'(grp)*W +: W]    = slice_s;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = RUN;
            RUN:     if (last_grp) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // Subtraction is a + ~b + ~bin; the carry register holds the running
    // carry, and borrow-out is its complement after the final group.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grp        <= '0;
            carry      <= 1'b0;
            a_reg      <= '0;
            nb_reg     <= '0;
            diff_reg   <= '0;
            borrow_reg <= 1'b0;
            zero_reg   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg  <= a;
                        nb_reg <= ~b;
                        carry  <= ~bin;
                        grp    <= '0;
                    end
                end
                RUN: begin
                    diff_reg <= diff_nxt;
                    carry    <= slice_co;
                    grp      <= grp + 1'b1;
                    if (last_grp) begin
                        borrow_reg <= ~slice_co;
                        zero_reg   <= (diff_nxt == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign diff   = diff_reg;
    assign borrow = borrow_reg;
    assign zero   = zero_reg;

endmodule

// File: tb/tb_cla_iter_subtractor.sv
// Self-checking bench for cla_iter_subtractor: directed vector table,
// back-pressure and mid-operation reset sequences, then random operands.
module tb_cla_iter_subtractor;

    localparam int DW   = 32;
    localparam int NGRP = 8;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          bin;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] diff;
    logic          borrow;
    logic          zero;

    cla_iter_subtractor #(.DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [DW-1:0] diff;
        logic          borrow;
        logic          zero;
    } result_t;

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic          bin;
        logic [DW-1:0] exp_diff;
        logic          exp_borrow;
        logic          exp_zero;
        int            stall;
    } vec_t;

    result_t sb_q[$];
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference model: 33-bit unsigned subtraction, bit 32 is the borrow.
    function automatic result_t model(input logic [DW-1:0] ra, input logic [DW-1:0] rb, input logic rbin);
        logic [DW:0] r;
        result_t     res;
        r          = {1'b0, ra} - {1'b0, rb} - {{DW{1'b0}}, rbin};
        res.diff   = r[DW-1:0];
        res.borrow = r[DW];
        res.zero   = (r[DW-1:0] == '0);
        return res;
    endfunction

    // Drive one operation, check latency, stall the output, then compare
    // against the scoreboard entry. poke raises a stray in_valid while stalled.
    task automatic do_op(input logic [DW-1:0] oa, input logic [DW-1:0] ob, input logic obin,
                         input int stall, input bit poke);
        int      acc;
        int      waited;
        result_t exp_r;
        result_t held;
        @(negedge clk);
        waited = 0;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", {63'd0, in_ready}, 64'd1);
            return;
        end
        in_valid = 1'b1;
        a        = oa;
        b        = ob;
        bin      = obin;
        sb_q.push_back(model(oa, ob, obin));
        @(posedge clk);
        #1;
        acc = cyc;
        @(negedge clk);
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        bin      = 1'($urandom_range(0, 1));
        waited   = 0;
        while (!out_valid && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        exp_r = sb_q.pop_front();
        if (!out_valid) begin
            check("out_valid_timeout", {63'd0, out_valid}, 64'd1);
            return;
        end
        check("latency", 64'(cyc - acc), 64'(NGRP));
        held = '{diff: diff, borrow: borrow, zero: zero};
        for (int i = 0; i < stall; i++) begin
            if (poke) begin
                in_valid = 1'b1;
                a        = 32'hDEAD_BEEF;
                b        = 32'h0000_0001;
            end
            @(negedge clk);
            in_valid = 1'b0;
            check("stall_out_valid", {63'd0, out_valid}, 64'd1);
            check("stall_in_ready", {63'd0, in_ready}, 64'd0);
            check("stall_hold", {31'd0, diff, borrow, zero}, {31'd0, held.diff, held.borrow, held.zero});
        end
        out_ready = 1'b1;
        check("diff", 64'(diff), 64'(exp_r.diff));
        check("borrow", 64'(borrow), 64'(exp_r.borrow));
        check("zero", 64'(zero), 64'(exp_r.zero));
        @(negedge clk);
        out_ready = 1'b0;
        check("post_in_ready", {63'd0, in_ready}, 64'd1);
        check("post_out_valid", {63'd0, out_valid}, 64'd0);
    endtask

    vec_t vecs[$];

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        bin       = 1'b0;

        vecs.push_back('{32'd5,          32'd3,          1'b0, 32'h0000_0002, 1'b0, 1'b0, 0});
        vecs.push_back('{32'd3,          32'd5,          1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0, 1});
        vecs.push_back('{32'd0,          32'd0,          1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 0});
        vecs.push_back('{32'h8000_0000,  32'h8000_0000,  1'b0, 32'h0000_0000, 1'b0, 1'b1, 2});
        vecs.push_back('{32'h0001_0000,  32'd1,          1'b0, 32'h0000_FFFF, 1'b0, 1'b0, 0});
        vecs.push_back('{32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 0});
        vecs.push_back('{32'd0,          32'hFFFF_FFFF,  1'b0, 32'h0000_0001, 1'b1, 1'b0, 1});
        vecs.push_back('{32'hFFFF_FFFF,  32'd0,          1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 0});
        vecs.push_back('{32'd1,          32'd0,          1'b1, 32'h0000_0000, 1'b0, 1'b1, 0});

        #12;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_outputs", {31'd0, diff, borrow, zero}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);

        // Directed table: cross-check the table against the model, then run.
        foreach (vecs[i]) begin
            result_t m;
            m = model(vecs[i].a, vecs[i].b, vecs[i].bin);
            check("table_model", {31'd0, m.diff, m.borrow, m.zero},
                  {31'd0, vecs[i].exp_diff, vecs[i].exp_borrow, vecs[i].exp_zero});
            do_op(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].stall, 1'b0);
        end

        // Back-pressure with a stray in_valid while DONE, then a follow-up op.
        do_op(32'h1234_5678, 32'h0000_1111, 1'b0, 5, 1'b1);
        do_op(32'd7, 32'd7, 1'b0, 0, 1'b0);

        // Reset asynchronously during RUN, then a fresh operation.
        @(negedge clk);
        in_valid = 1'b1;
        a        = 32'hFFFF_0000;
        b        = 32'h0000_1234;
        bin      = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        check("midrst_outputs", {31'd0, diff, borrow, zero}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        do_op(32'd10, 32'd4, 1'b0, 0, 1'b0);

        // Random operands with random output stalls.
        for (int i = 0; i < 2000; i++) begin
            do_op($urandom, ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 3)) : $urandom,
                  1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b0);
        end

        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
